// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the sync_fifo_param FIFO family.
// Derives depth and pointer width from the address width and validates thresholds.
package fifo_pkg;

    typedef struct packed {
        logic full;
        logic almost_full;
        logic empty;
        logic almost_empty;
    } fifo_flags_t;

    function automatic int unsigned fifo_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

    // One extra pointer bit distinguishes full from empty when the low bits match.
    function automatic int unsigned fifo_ptr_w(input int unsigned addr_w);
        return addr_w + 32'd1;
    endfunction

    function automatic logic fifo_th_legal(input int unsigned addr_w,
                                           input int unsigned afull_th,
                                           input int unsigned aempty_th);
        int unsigned depth;
        depth = fifo_depth(addr_w);
        return (afull_th >= 32'd1) && (afull_th <= depth) && (aempty_th <= depth - 32'd1);
    endfunction

endpackage

// File: rtl/fifo_mem_regs.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module fifo_mem_regs
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 11,
    parameter int unsigned ADDR_W = 3
)(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_W);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Storage write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with level, almost-full/empty thresholds and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is 1-cycle registered read.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = 11,
    parameter int unsigned ADDR_W    = 3,
    parameter int unsigned AFULL_TH  = 6,
    parameter int unsigned AEMPTY_TH = 2
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    output logic              wr_full,
    output logic              wr_almost_full,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              rd_empty,
    output logic              rd_almost_empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned PTR_W = fifo_ptr_w(ADDR_W);

    if (!fifo_th_legal(ADDR_W, AFULL_TH, AEMPTY_TH)) begin : g_th_check
        $fatal(1, "sync_fifo_param: AFULL_TH or AEMPTY_TH out of range");
    end

    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  level_s;
    fifo_flags_t       flags_s;
    logic              wr_accept_s;
    logic              rd_accept_s;
    logic              overflow_r;
    logic              underflow_r;
    logic [DATA_W-1:0] rdata_s;

    // Flag decode from registered pointers only
    always_comb begin
        level_s               = wr_ptr_r - rd_ptr_r;
        flags_s.full          = (wr_ptr_r[ADDR_W-1:0] == rd_ptr_r[ADDR_W-1:0]) &&
                                (wr_ptr_r[ADDR_W] != rd_ptr_r[ADDR_W]);
        flags_s.empty         = (wr_ptr_r == rd_ptr_r);
        flags_s.almost_full   = (level_s >= PTR_W'(AFULL_TH));
        flags_s.almost_empty  = (level_s <= PTR_W'(AEMPTY_TH));
    end

    assign wr_accept_s = wr_en && !flags_s.full;
    assign rd_accept_s = rd_en && !flags_s.empty;

    // Pointer advance and error pulse generation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (rd_accept_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            overflow_r  <= wr_en && flags_s.full;
            underflow_r <= rd_en && flags_s.empty;
        end
    end

    fifo_mem_regs #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_accept_s),
        .waddr (wr_ptr_r[ADDR_W-1:0]),
        .wdata (data_in),
        .raddr (rd_ptr_r[ADDR_W-1:0]),
        .rdata (rdata_s)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign data_out = rdata_s;
    assign rd_valid = !flags_s.empty;
`else
    logic [DATA_W-1:0] data_out_r;
    logic              rd_valid_r;

    // Registered read: head word captured on the accepting edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_r <= {DATA_W{1'b0}};
            rd_valid_r <= 1'b0;
        end else if (rd_accept_s) begin
            data_out_r <= rdata_s;
            rd_valid_r <= 1'b1;
        end else begin
            rd_valid_r <= 1'b0;
        end
    end

    assign data_out = data_out_r;
    assign rd_valid = rd_valid_r;
`endif

    assign wr_full         = flags_s.full;
    assign wr_almost_full  = flags_s.almost_full;
    assign rd_empty        = flags_s.empty;
    assign rd_almost_empty = flags_s.almost_empty;
    assign level           = level_s;
    assign overflow        = overflow_r;
    assign underflow       = underflow_r;

endmodule
